pool_frame_arbiter: RTL and testbench

//  Shares one pooling_unit between NREQ upstream feature-map streams, one whole frame at a time.
//  - Grants one requester round-robin and forwards its IF_BEATS input beats into the pooling unit.
//  - Routes the OF_BEATS pooled output beats back to that requester only, then re-arbitrates.
//  - Sits between the tile's crossbar/conv outputs and the pooling_unit instance.

---
 rtl/pool_frame_arbiter.sv | 167 ++++++++++++++++
 tb/tb_pool_frame_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_frame_arbiter.sv
// pool_frame_arbiter: lends one pooling unit to NREQ streams a frame at a time,
// round-robin, feeding the owner's beats in and routing pooled beats back.
module pool_frame_arbiter #(
   parameter int NREQ     = 4,
   parameter int IF_BEATS = 64,
   parameter int OF_BEATS = 16,
   parameter int XW       = 2,
   parameter int QW       = 8,
   localparam int OW      = $clog2(NREQ),
   localparam int ICW     = $clog2(IF_BEATS + 1),
   localparam int OCW     = $clog2(OF_BEATS + 1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NREQ-1:0][XW-1:0][QW-1:0] req_data_i,
   input  logic [NREQ-1:0]                 req_valid_i,
   output logic [NREQ-1:0]                 req_ready_o,
   output logic [XW-1:0][QW-1:0]           pu_data_o,
   output logic                            pu_valid_o,
   input  logic                            pu_ready_i,
   input  logic [XW-1:0][QW-1:0]           pu_data_i,
   input  logic                            pu_valid_i,
   output logic                            pu_ready_o,
   output logic [XW-1:0][QW-1:0]           rsp_data_o,
   output logic [NREQ-1:0]                 rsp_valid_o,
   input  logic [NREQ-1:0]                 rsp_ready_i,
   output logic [OW-1:0]                   owner_o,
   output logic                            busy_o,
   output logic                            frame_done_o,
   output logic                            err_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [OW-1:0]  owner_q, owner_d;
   logic [OW-1:0]  rr_q, rr_d;
   logic [ICW-1:0] in_q, in_d;
   logic [OCW-1:0] out_q, out_d;
   logic           err_q, err_d;
   logic           done_q, done_d;

   logic           feed;
   logic           act;
   logic           in_hs;
   logic           out_hs;
   logic           last_in;
   logic           last_out;
   logic           grant_vld;
   logic [OW-1:0]  grant_idx;
   logic [OW-1:0]  owner_nxt;

   assign feed     = (state_q == FEED);
   assign act      = (state_q != IDLE);
   assign pu_data_o  = req_data_i[owner_q];
   assign pu_valid_o = feed & req_valid_i[owner_q];
   assign pu_ready_o = act & rsp_ready_i[owner_q];
   assign rsp_data_o = pu_data_i;
   assign in_hs    = pu_valid_o & pu_ready_i;
   assign out_hs   = act & pu_valid_i & pu_ready_o;
   assign last_in  = in_hs & (in_q == ICW'(IF_BEATS - 1));
   assign last_out = out_hs & (out_q == OCW'(OF_BEATS - 1));
   assign owner_nxt = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

   assign owner_o      = owner_q;
   assign busy_o       = act;
   assign frame_done_o = done_q;
   assign err_o        = err_q;

   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      if (feed)
         req_ready_o[owner_q] = pu_ready_i;
      if (act)
         rsp_valid_o[owner_q] = pu_valid_i;
   end

   // Scan downward so the candidate closest to rr_q is written last and wins.
   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(rr_q) + k) % NREQ;
         if (req_valid_i[idx]) begin
            grant_vld = 1'b1;
            grant_idx = OW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      in_d    = in_q;
      out_d   = out_q;
      err_d   = err_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pu_valid_i)
               err_d = 1'b1;
            if (grant_vld) begin
               owner_d = grant_idx;
               state_d = FEED;
            end
         end
         FEED: begin
            if (in_hs)
               in_d = in_q + ICW'(1);
            if (out_hs)
               out_d = out_q + OCW'(1);
            if (last_out) begin
               if (!last_in)
                  err_d = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
               rr_d    = owner_nxt;
               in_d    = '0;
               out_d   = '0;
            end else if (last_in) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_hs)
               out_d = out_q + OCW'(1);
            if (last_out) begin
               done_d  = 1'b1;
               state_d = IDLE;
               rr_d    = owner_nxt;
               in_d    = '0;
               out_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         in_q    <= '0;
         out_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         in_q    <= in_d;
         out_q   <= out_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_pool_frame_arbiter.sv
// Bench for pool_frame_arbiter: random traffic against a frame-level model,
// with the bench also playing the pooling unit.
module tb_pool_frame_arbiter;

   localparam int NREQ = 4;
   localparam int IFB  = 64;
   localparam int OFB  = 16;
   localparam int XW   = 2;
   localparam int QW   = 8;
   localparam int DW   = XW * QW;

   logic                            clk = 1'b0;
   logic                            rst = 1'b1;
   logic [NREQ-1:0][XW-1:0][QW-1:0] req_data = '0;
   logic [NREQ-1:0]                 req_valid = '0;
   logic [NREQ-1:0]                 req_ready;
   logic [XW-1:0][QW-1:0]           pu_data_o;
   logic                            pu_valid_o;
   logic                            pu_ready_i = 1'b0;
   logic [XW-1:0][QW-1:0]           pu_data_i = '0;
   logic                            pu_valid_i = 1'b0;
   logic                            pu_ready_o;
   logic [XW-1:0][QW-1:0]           rsp_data;
   logic [NREQ-1:0]                 rsp_valid;
   logic [NREQ-1:0]                 rsp_ready = '0;
   logic [1:0]                      owner;
   logic                            busy;
   logic                            frame_done;
   logic                            err;

   pool_frame_arbiter #(
      .NREQ(NREQ), .IF_BEATS(IFB), .OF_BEATS(OFB), .XW(XW), .QW(QW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_data_i(req_data), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .pu_data_o(pu_data_o), .pu_valid_o(pu_valid_o), .pu_ready_i(pu_ready_i),
      .pu_data_i(pu_data_i), .pu_valid_i(pu_valid_i), .pu_ready_o(pu_ready_o),
      .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .owner_o(owner), .busy_o(busy), .frame_done_o(frame_done), .err_o(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // frame-level model state
   logic m_busy = 0;
   int   m_owner = 0, m_rr = 0, m_in = 0, m_out = 0;
   logic m_err = 0, m_done = 0;
   int   frames = 0;
   int   grant_log[$];
   int   beats_in[NREQ], beats_out[NREQ];

   // stimulus knobs
   logic            rst_req = 1;
   logic [NREQ-1:0] req_mask = '0;
   int              p_req[NREQ];
   int              p_pu = 80, p_rsp = 80, p_emit = 60;
   int              stall_left = 0;
   logic            same_mode = 0, rogue_idle = 0, rogue_feed = 0;
   int              cyc = 0, dut_done_cnt = 0, lastin_cyc = 0, done_cyc = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      logic            in_hs, out_hs, feeding;
      logic [NREQ-1:0] e_rr, e_rv;
      int              g;
      @(negedge clk);
      cyc++;
      rst = rst_req;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i] = req_mask[i] && ($urandom_range(99) < p_req[i]);
         req_data[i]  = DW'($urandom);
         rsp_ready[i] = $urandom_range(99) < p_rsp;
      end
      pu_ready_i = $urandom_range(99) < p_pu;
      if (stall_left > 0 && m_busy && m_in == IFB) begin
         rsp_ready[m_owner] = 1'b0;
         stall_left--;
      end
      feeding = m_busy && (m_in < IFB);
      in_hs   = feeding && req_valid[m_owner] && pu_ready_i;
      pu_valid_i = 1'b0;
      if (!m_busy)
         pu_valid_i = rogue_idle;
      else if (m_out < OFB) begin
         if (rogue_feed)
            pu_valid_i = 1'b1;
         else if (same_mode && m_out == OFB - 1 && m_in == IFB - 1)
            pu_valid_i = in_hs;
         else if (m_out < m_in / 4)
            pu_valid_i = $urandom_range(99) < p_emit;
      end
      pu_data_i = DW'($urandom);
      #1;
      e_rr = '0;
      e_rv = '0;
      if (feeding && pu_ready_i) e_rr[m_owner] = 1'b1;
      if (m_busy && pu_valid_i) e_rv[m_owner] = 1'b1;
      chk("busy", busy, m_busy);
      chk("owner", owner, m_owner);
      chk("frame_done", frame_done, m_done);
      chk("err", err, m_err);
      chk("req_ready", req_ready, e_rr);
      chk("pu_valid_o", pu_valid_o, feeding && req_valid[m_owner]);
      chk("pu_ready_o", pu_ready_o, m_busy && rsp_ready[m_owner]);
      chk("rsp_valid", rsp_valid, e_rv);
      if (feeding && req_valid[m_owner])
         chk("pu_data_o", pu_data_o, req_data[m_owner]);
      if (e_rv != 0)
         chk("rsp_data", rsp_data, pu_data_i);
      if (frame_done) begin
         dut_done_cnt++;
         done_cyc = cyc;
      end
      if (pu_valid_o && pu_ready_i) lastin_cyc = cyc;
      // model update
      out_hs = m_busy && pu_valid_i && rsp_ready[m_owner];
      m_done = 1'b0;
      if (rst) begin
         m_busy = 0; m_owner = 0; m_rr = 0; m_in = 0; m_out = 0; m_err = 0;
      end else if (!m_busy) begin
         if (pu_valid_i) m_err = 1'b1;
         g = -1;
         for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
         if (g >= 0) begin
            m_busy = 1'b1;
            m_owner = g;
            grant_log.push_back(g);
         end
      end else begin
         if (in_hs) beats_in[m_owner]++;
         if (out_hs) beats_out[m_owner]++;
         if (out_hs && m_out == OFB - 1) begin
            if (m_in < IFB && !(in_hs && m_in == IFB - 1)) m_err = 1'b1;
            m_done = 1'b1;
            m_busy = 1'b0;
            m_rr = (m_owner + 1) % NREQ;
            m_in = 0;
            m_out = 0;
            frames++;
         end else begin
            m_in += int'(in_hs);
            m_out += int'(out_hs);
         end
      end
   endtask

   task automatic run_frames(int n, int budget, string name);
      int target, c;
      target = frames + n;
      c = 0;
      while (frames < target && c < budget) begin
         step();
         c++;
      end
      total++;
      if (frames < target) begin
         bad++;
         $display("FAIL timeout_%s: frames %0d want %0d", name, frames, target);
      end
   endtask

   task automatic do_reset();
      rst_req = 1;
      req_mask = '0;
      step();
      rst_req = 0;
   endtask

   initial begin
      int g0;
      for (int i = 0; i < NREQ; i++) p_req[i] = 70;
      step();
      step();
      chk("reset_busy", busy, 0);
      chk("reset_req_ready", req_ready, 0);
      chk("reset_err", err, 0);
      rst_req = 0;

      // single requester 1
      req_mask = 4'b0010;
      step();
      step();
      chk("s1_owner", owner, 1);
      run_frames(1, 3000, "s1");
      req_mask = '0;
      step();
      chk("s1_grant", grant_log[0], 1);
      chk("s1_in", beats_in[1], IFB);
      chk("s1_out", beats_out[1], OFB);
      chk("s1_done_pulses", dut_done_cnt, 1);
      chk("s1_other_out", beats_out[0] + beats_out[2] + beats_out[3], 0);
      g0 = grant_log.size();
      req_mask = 4'b1111;
      run_frames(1, 3000, "rr");
      chk("rr_next", grant_log[g0], 2);

      // all requesters always valid from reset
      do_reset();
      for (int i = 0; i < NREQ; i++) p_req[i] = 100;
      g0 = grant_log.size();
      req_mask = 4'b1111;
      run_frames(8, 12000, "s2");
      for (int k = 0; k < 8; k++)
         chk("s2_order", grant_log[g0 + k], k % 4);

      // owners stall randomly, req2 always valid
      for (int i = 0; i < NREQ; i++) p_req[i] = 40;
      p_req[2] = 100;
      run_frames(4, 12000, "s3");

      // rsp stall during drain
      p_req = '{100, 100, 100, 100};
      p_pu = 100;
      p_rsp = 100;
      stall_left = 20;
      run_frames(2, 4000, "s4");
      chk("s4_stall_used", stall_left, 0);

      // last output coincides with last input
      req_mask = '0;
      step();
      step();
      do_reset();
      same_mode = 1;
      p_emit = 100;
      req_mask = 4'b0001;
      run_frames(1, 2000, "s5");
      req_mask = '0;
      step();
      chk("s5_err", err, 0);
      chk("s5_direct", done_cyc - lastin_cyc, 1);
      same_mode = 0;
      p_pu = 80;
      p_rsp = 80;
      p_emit = 60;

      // outputs finishing before inputs
      rogue_feed = 1;
      req_mask = 4'b0001;
      p_req[0] = 30;
      run_frames(1, 2000, "early");
      rogue_feed = 0;
      req_mask = '0;
      step();
      chk("early_err", err, 1);
      do_reset();
      step();
      chk("early_clr", err, 0);

      // pu_valid_i in IDLE, then reset mid-frame
      rogue_idle = 1;
      repeat (3) step();
      rogue_idle = 0;
      chk("idle_err", err, 1);
      req_mask = 4'b0001;
      p_req[0] = 100;
      for (int c = 0; c < 500 && !(m_busy && m_in > 10); c++) step();
      chk("midframe_busy", busy, 1);
      do_reset();
      step();
      chk("post_rst_err", err, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_owner", owner, 0);
      chk("post_rst_rsp", rsp_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
